// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier between two requesters.
// Operands are latched at grant and held on the multiplier port until the response leaves.
module mult_sched #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_ctrl,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic [4:0]  m_ctrl,
  output logic        m_start,
  input  logic        m_done,
  input  logic [31:0] m_lower,
  input  logic [31:0] m_higher,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_lower,
  output logic [31:0] rsp_higher,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       rr_prio;
  logic       grant_any;
  logic       grant_id;

  // rr_prio names the requester that wins when both are pending.
  always_comb begin
    grant_any = (state == S_IDLE) && !rst && (req0_valid || req1_valid);
    grant_id  = (req0_valid && req1_valid) ? rr_prio : req1_valid;
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;
  assign m_start    = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr_prio    <= 1'b0;
      rsp_id     <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_ctrl     <= '0;
      rsp_lower  <= '0;
      rsp_higher <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            m_a     <= grant_id ? req1_a    : req0_a;
            m_b     <= grant_id ? req1_b    : req0_b;
            m_ctrl  <= grant_id ? req1_ctrl : req0_ctrl;
            rsp_id  <= grant_id;
            rr_prio <= ~grant_id;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse on the last allowed cycle still counts as success.
          if (m_done) begin
            rsp_lower  <= m_lower;
            rsp_higher <= m_higher;
            rsp_err    <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == TO_LAST) begin
            rsp_lower  <= '0;
            rsp_higher <= '0;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: directed operations, a behavioural multiplier,
// and a monitor that checks every response handshake against queued expectations.
module tb_mult_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_ctrl;
  logic        m_start, m_done;
  logic [31:0] m_lower, m_higher;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_lower, rsp_higher;

  mult_sched #(.TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .m_a(m_a), .m_b(m_b), .m_ctrl(m_ctrl), .m_start(m_start), .m_done(m_done),
    .m_lower(m_lower), .m_higher(m_higher),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lower(rsp_lower), .rsp_higher(rsp_higher), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          n_start = 0;
  bit          outstanding = 0;

  bit          mdl_en   = 1;
  bit          mdl_echo = 1;
  int          mdl_delay = 3;
  logic [31:0] mdl_lo = '0;
  logic [31:0] mdl_hi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural multiplier: pulses m_done mdl_delay cycles after the start cycle.
  initial begin
    m_done = 1'b0; m_lower = '0; m_higher = '0;
    forever begin
      @(negedge clk);
      if (m_start && mdl_en) begin
        repeat (mdl_delay) @(posedge clk);
        #1;
        m_done   = 1'b1;
        m_lower  = mdl_echo ? m_a : mdl_lo;
        m_higher = mdl_echo ? m_b : mdl_hi;
        @(posedge clk);
        #1;
        m_done = 1'b0; m_lower = '0; m_higher = '0;
      end
    end
  end

  // Monitor: response handshakes against the scoreboard, start pulses against overlap.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) outstanding = 0;
      if (m_start) begin
        n_start++;
        chk("start_overlap", {31'd0, outstanding}, 32'd0);
        outstanding = 1;
      end
      if (rsp_valid && rsp_ready) begin
        outstanding = 0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got id %0d lower %h, expected no response", rsp_id, rsp_lower);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id",     {31'd0, rsp_id},  {31'd0, e.id});
          chk("rsp_lower",  rsp_lower,        e.lo);
          chk("rsp_higher", rsp_higher,       e.hi);
          chk("rsp_err",    {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic drive_req(input bit id, input logic v, input logic [31:0] a, b, input logic [4:0] c);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  // One operation from a single requester; lat is m_start cycle to first rsp_valid cycle.
  task automatic run_op(input bit id, input logic [31:0] a, b, input logic [4:0] c,
                        input logic [31:0] elo, ehi, input bit eerr, input int lat);
    bit ok;
    int t_start;
    exp_q.push_back('{id, elo, ehi, eerr});
    @(posedge clk); #1;
    drive_req(id, 1'b1, a, b, c);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    chk("grant_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    drive_req(id, 1'b0, a, b, c);
    @(negedge clk);
    t_start = cyc;
    chk("m_start", {31'd0, m_start}, 32'd1);
    chk("m_a", m_a, a);
    chk("m_b", m_b, b);
    chk("m_ctrl", {27'd0, m_ctrl}, {27'd0, c});
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rsp_seen", {31'd0, ok}, 32'd1);
    chk("latency", cyc - t_start, lat);
    wait_idle();
  endtask

  initial begin
    int  s0;
    bit  ok;
    bit  saw;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;

    // Reset state and ready gating under reset
    repeat (3) @(posedge clk);
    #1; req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_m_start", {31'd0, m_start}, 32'd0);
    chk("rst_m_a", m_a, 32'd0);
    chk("rst_rsp_lower", rsp_lower, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b0;

    // Both requesters pending continuously: grants 0,1,0,1
    mdl_echo = 1; mdl_delay = 3; mdl_en = 1;
    exp_q.push_back('{1'b0, 32'h100, 32'h200, 1'b0});
    exp_q.push_back('{1'b1, 32'h111, 32'h222, 1'b0});
    exp_q.push_back('{1'b0, 32'h100, 32'h200, 1'b0});
    exp_q.push_back('{1'b1, 32'h111, 32'h222, 1'b0});
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'h100, 32'h200, 5'h01);
    drive_req(1, 1'b1, 32'h111, 32'h222, 5'h0A);
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1; break; end
      end
      chk("rr_grant_seen", {31'd0, ok}, 32'd1);
      chk("rr_grant_id", {31'd0, req1_ready}, k % 2);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Single op from requester 0, multiplier answers 33 cycles after start
    mdl_echo = 0; mdl_lo = 32'd42; mdl_hi = 32'd0; mdl_delay = 33;
    s0 = n_start;
    run_op(0, 32'd7, 32'd6, 5'h03, 32'd42, 32'd0, 1'b0, 34);
    chk("single_start_count", n_start - s0, 1);

    // Multiplier silent: timeout, then a normal op
    mdl_en = 0;
    run_op(1, 32'h1234, 32'h5678, 5'h1C, 32'd0, 32'd0, 1'b1, 41);
    mdl_en = 1; mdl_echo = 1; mdl_delay = 2;
    run_op(0, 32'd3, 32'd4, 5'h02, 32'd3, 32'd4, 1'b0, 3);

    // Done pulse coincides with the final timeout cycle
    mdl_echo = 0; mdl_lo = 32'hFFFF_FFFF; mdl_hi = 32'h1; mdl_delay = 40;
    run_op(1, 32'd9, 32'd9, 5'h13, 32'hFFFF_FFFF, 32'h1, 1'b0, 41);

    // Consumer stalls 10 cycles in RESP while requester 0 waits
    mdl_echo = 1; mdl_delay = 4; rsp_ready = 0;
    exp_q.push_back('{1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0});
    exp_q.push_back('{1'b0, 32'd5, 32'd9, 1'b0});
    @(posedge clk); #1;
    drive_req(1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 5'h04);
    @(negedge clk);
    chk("stall_grant", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("stall_rsp_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd5, 32'd9, 5'h07);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_lower", rsp_lower, 32'hAAAA_0001);
      chk("hold_higher", rsp_higher, 32'hBBBB_0002);
      chk("hold_id", {31'd0, rsp_id}, 32'd1);
      chk("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("hold_m_start", {31'd0, m_start}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    chk("handshake_no_grant", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    chk("post_handshake_grant", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_idle();

    // Reset in WAIT with a late done pulse, then round-robin restarts at requester 0
    mdl_delay = 20;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd1, 32'd2, 5'h05);
    @(negedge clk);
    chk("pre_rst_grant", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (6) @(posedge clk);
    #1; rst = 1; req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_wait_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_wait_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_m_a", m_a, 32'd0);
    chk("rstw_m_b", m_b, 32'd0);
    chk("rstw_m_ctrl", {27'd0, m_ctrl}, 32'd0);
    chk("rstw_rsp_lower", rsp_lower, 32'd0);
    chk("rstw_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rstw_rsp_id", {31'd0, rsp_id}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) saw = 1;
    end
    chk("late_done_ignored", {31'd0, saw}, 32'd0);
    mdl_delay = 3;
    exp_q.push_back('{1'b0, 32'h30, 32'h31, 1'b0});
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'h30, 32'h31, 5'h00);
    drive_req(1, 1'b1, 32'h40, 32'h41, 5'h00);
    @(negedge clk);
    chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
